// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types: stall/flush codes, controller FSM states
// and the default mul/div latencies.
package hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        NOSTALL = 3'd0,
        STALLF  = 3'd1,
        STALLD  = 3'd2,
        STALLE  = 3'd3,
        STALLM  = 3'd4,
        STALLW  = 3'd5
    } stall_t;

    typedef enum logic {
        NOFLUSH = 1'b0,
        FLUSHD  = 1'b1
    } flush_t;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_DRAIN = 2'd1,
        F_REDIR = 2'd2
    } hazard_fetch_state_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam int DEF_MUL_LAT = 3;
    localparam int DEF_DIV_LAT = 65;
    localparam int DEF_CNT_W   = 7;

    // A register-0 destination never creates a dependency.
    function automatic logic load_use_hit(
        input logic       ex_load,
        input logic [4:0] ex_rd,
        input logic [4:0] de_rs1,
        input logic [4:0] de_rs2,
        input logic       de_use1,
        input logic       de_use2
    );
        return ex_load && (ex_rd != 5'd0) &&
               ((de_use1 && (de_rs1 == ex_rd)) || (de_use2 && (de_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Mul/div occupancy timer: counts the execute-stage cycles of a multi-cycle
// op and then waits in MD_DONE until E/M captures the result.
module md_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic is_div,
    input  logic hold,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The start cycle itself is the first occupied cycle, so the counter is
    // loaded with LAT-1 and BUSY is left when it reaches zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    cnt_next   = is_div ? DIV_CNT : MUL_CNT;
                    state_next = (cnt_next == '0) ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt_next == '0) begin
                    state_next = MD_DONE;
                end
            end
            MD_DONE: begin
                if (!hold) begin
                    state_next = MD_IDLE;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Central 5-stage pipeline controller: stall/flush codes, branch redirect
// sequencing against in-flight fetches, and mul/div occupancy in execute.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_wait,
    input  logic        i_ok,
    input  logic        d_wait,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  de_rs1,
    input  logic [4:0]  de_rs2,
    input  logic        de_use1,
    input  logic        de_use2,
    input  logic        md_start,
    input  logic        md_is_div,
    output stall_t      stop,
    output flush_t      bubble,
    output logic        pc_redirect,
    output logic [63:0] pc_target,
    output logic        discard_fetch,
    output logic        md_busy
);

    hazard_fetch_state_t f_state, f_next;
    logic [63:0]         tgt_q, tgt_next;
    stall_t              stop_c;
    logic                md_done;
    logic                md_stall;
    logic                load_use;
    logic                accept;

    md_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_timer (
        .clk    (clk),
        .resetn (resetn),
        .start  (md_start),
        .is_div (md_is_div),
        .hold   (stop_c == STALLM),
        .busy   (md_busy),
        .done   (md_done)
    );

    // md_start is ignored once the op has finished and awaits capture.
    assign md_stall = md_busy || (md_start && !md_done);
    assign load_use = load_use_hit(ex_load, ex_rd, de_rs1, de_rs2, de_use1, de_use2);

    always_comb begin
        stop_c = NOSTALL;
        if (d_wait) begin
            stop_c = STALLM;
        end else if (md_stall) begin
            stop_c = STALLE;
        end else if (load_use) begin
            stop_c = STALLD;
        end else if (i_wait || (f_state == F_DRAIN)) begin
            stop_c = STALLF;
        end
    end

    // Reset forces quiet outputs even while the inputs are still active.
    assign stop   = resetn ? stop_c : NOSTALL;
    assign accept = resetn && br_taken && (stop_c != STALLM) && (stop_c != STALLE);
    assign bubble = accept ? FLUSHD : NOFLUSH;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_state <= F_IDLE;
            tgt_q   <= '0;
        end else begin
            f_state <= f_next;
            tgt_q   <= tgt_next;
        end
    end

    // A redirect taken while a fetch is outstanding must wait for that
    // response to be dropped; a newer branch always replaces the old target.
    always_comb begin
        f_next        = f_state;
        tgt_next      = tgt_q;
        pc_redirect   = 1'b0;
        pc_target     = '0;
        discard_fetch = 1'b0;
        case (f_state)
            F_IDLE: begin
                if (accept) begin
                    if (i_wait && !i_ok) begin
                        f_next   = F_DRAIN;
                        tgt_next = br_target;
                    end else begin
                        pc_redirect = 1'b1;
                        pc_target   = br_target;
                    end
                end
            end
            F_DRAIN: begin
                discard_fetch = 1'b1;
                if (accept) begin
                    tgt_next = br_target;
                end
                if (i_ok) begin
                    f_next = F_REDIR;
                end
            end
            F_REDIR: begin
                pc_redirect = 1'b1;
                pc_target   = accept ? br_target : tgt_q;
                f_next      = F_IDLE;
            end
            default: f_next = F_IDLE;
        endcase
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Produces the per-cycle `stop` (stall_t) and `bubble` (flush_t) codes consumed by every inter-stage register (regfd, regde, regem, regmw).
- Sequences taken-branch redirects against an in-flight instruction fetch, and times the multi-cycle mul/div unit in execute.
- Sits beside the pipeline, fed by decode/execute hazard info and the ibus/dbus wait flags.

Parameters:
- MUL_LAT, 3, cycles execute is occupied by a multiply (>=1).
- DIV_LAT, 65, cycles execute is occupied by a divide (>=1).
- CNT_W, 7, width of the mul/div counter; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- i_wait  in  1  ibus request outstanding, no response yet.
- i_ok  in  1  ibus response handshake this cycle.
- d_wait  in  1  dbus request from memory stage outstanding.
- br_taken  in  1  execute resolves a taken branch/jump.
- br_target  in  64  redirect PC.
- ex_load  in  1  execute holds a load.
- ex_rd  in  5  execute destination register.
- de_rs1, de_rs2  in  5 each  decode source registers.
- de_use1, de_use2  in  1 each  decode actually reads rs1/rs2.
- md_start  in  1  execute holds a mul/div.
- md_is_div  in  1  qualifies md_start.
- stop  out  stall_t  stall code.
- bubble  out  flush_t  flush code.
- pc_redirect  out  1  fetch loads pc_target next edge.
- pc_target  out  64  redirect PC.
- discard_fetch  out  1  returning ibus data is wrong-path; drop it.
- md_busy  out  1  mul/div occupying execute.

Behaviour:
- stall_t encoding:
  - NOSTALL: everything advances.
  - STALLF: F/D loads bubble.
  - STALLD: F and D/PC hold; D/E loads bubble.
  - STALLE: F..E hold; E/M loads bubble.
  - STALLM: F..M hold; M/W loads bubble.
  - STALLW: reserved, never driven.
- flush_t encoding:
  - NOFLUSH: no flush.
  - FLUSHD: F/D and D/E load bubble.
- Stop priority (combinational, highest first):
  1. d_wait -> STALLM.
  2. mul/div occupancy -> STALLE.
  3. Load-use -> STALLD. Load-use = ex_load && ex_rd != 0 && ((de_use1 && de_rs1 == ex_rd) || (de_use2 && de_rs2 == ex_rd)).
  4. i_wait or fetch FSM in F_DRAIN -> STALLF.
  5. Otherwise NOSTALL.
- Redirect acceptance:
  - Accepted only when br_taken && stop not in {STALLM, STALLE}. A branch held in E re-presents until accepted.
  - Accepted cycle drives bubble = FLUSHD; otherwise bubble = NOFLUSH.
- Fetch FSM (F_IDLE, F_DRAIN, F_REDIR):
  - F_IDLE, accepted redirect, i_wait && !i_ok:
    - latch br_target.
    - go to F_DRAIN.
    - no pc_redirect this cycle.
  - F_IDLE, accepted redirect, otherwise:
    - pc_redirect = 1 and pc_target = br_target combinationally in the same cycle.
    - stay in F_IDLE.
  - F_DRAIN:
    - discard_fetch = 1.
    - on i_ok go to F_REDIR.
    - an accepted redirect here overwrites the latched target.
  - F_REDIR:
    - pc_redirect = 1, pc_target = latched target, for exactly one cycle.
    - then go to F_IDLE.
- Mul/div FSM (MD_IDLE, MD_BUSY, MD_DONE), down-counter cnt:
  - MD_IDLE with md_start:
    - stop = STALLE this cycle.
    - cnt <= (md_is_div ? DIV_LAT : MUL_LAT) - 1.
    - if that value is 0, go to MD_DONE; else go to MD_BUSY.
  - MD_BUSY:
    - stop >= STALLE, md_busy = 1.
    - cnt decrements every cycle, regardless of d_wait.
    - at cnt == 0 go to MD_DONE.
  - MD_DONE:
    - no STALLE contribution.
    - md_start is ignored.
    - go to MD_IDLE on the first cycle with stop != STALLM, i.e. when E/M captures the result.
  - Total STALLE cycles per op = LAT when no d_wait overlaps.
- Reset (resetn low, any time, asynchronous):
  - FSMs go to F_IDLE / MD_IDLE; cnt = 0; latched target = 0.
  - Outputs while in reset: stop = NOSTALL, bubble = NOFLUSH, pc_redirect = 0, pc_target = 0, discard_fetch = 0, md_busy = 0.
- Widths: cnt is CNT_W bits; no wrap, since it is loaded only from IDLE and stops at 0.

Decomposition:
- Shared pipes package:
  - stall_t and flush_t enums (encodings above).
  - hazard_fetch_state_t and md_state_t enums.
  - MUL_LAT/DIV_LAT defaults as localparams.
- Natural sub-module: md_timer, the mul/div FSM plus counter, exporting busy and done.
- Stop priority, load-use compare and fetch FSM stay in hazard_ctrl.

Test Plan:
- Load-use: ex_load=1, ex_rd=5, de_rs1=5, de_use1=1 -> stop=STALLD for 1 cycle. Same stimulus with ex_rd=0 -> NOSTALL.
- Redirect, idle bus: br_taken=1, br_target=0x8000_0100, i_wait=0 -> bubble=FLUSHD and pc_redirect=1 with pc_target=0x8000_0100 in the same cycle.
- Redirect during fetch: br_taken with i_wait=1; i_ok arrives 3 cycles later:
  - discard_fetch=1 and stop=STALLF for those 3 cycles.
  - pc_redirect pulses 1 cycle after i_ok.
  - FLUSHD appears only in the accept cycle.
- Divide: md_start=1, md_is_div=1 -> stop=STALLE for exactly 65 cycles, then NOSTALL. Multiply -> 3 cycles.
- Overlap: d_wait=1 during a multiply and held 2 cycles past counter expiry -> stop=STALLM throughout; FSM stays MD_DONE, then returns to MD_IDLE once d_wait drops.
- Reset mid-operation: resetn low in MD_BUSY and F_DRAIN -> all outputs at reset values immediately, without waiting for a clock edge; after release, stop=NOSTALL.
